// File: rtl/pool_accum_regfile.sv
// ---------------------------------------------------------------------------
// pool_accum_regfile
//
// Multi-channel pooling register file. Each of DEPTH entries accumulates
// WIN_ELEMS samples (signed max or signed sum) across CHANNELS parallel lanes
// that share one address and handshake. When a window completes, one pooled
// vector is presented on a valid/ready output. Average pooling divides the
// sum by WIN_ELEMS with an arithmetic shift, which rounds toward -inf.
//
// Ports
//   clk        rising-edge clock
//   nrst       synchronous active-low reset
//   mode       0 = max pool, 1 = average pool (sampled per accepted sample)
//   clear      abandon all open windows (counters only; no sample accepted)
//   in_valid   sample valid
//   in_ready   sample accepted when in_valid & in_ready
//   in_addr    target entry
//   in_data    CHANNELS signed lanes, lane k at [k*DATA_W +: DATA_W]
//   out_valid  pooled result valid
//   out_ready  consumer accepts
//   out_addr   entry that completed
//   out_data   pooled result, same lane packing as in_data
//   busy       some entry has an open (partially filled) window
// ---------------------------------------------------------------------------
module pool_accum_regfile #(
  parameter int DATA_W    = 16,
  parameter int CHANNELS  = 4,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int WIN_ELEMS = 4,
  parameter int ACC_W     = DATA_W + $clog2(WIN_ELEMS)
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic                         mode,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            in_addr,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         busy
);

  localparam int CNT_W = $clog2(WIN_ELEMS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_ELEMS - 1);

  // Entry storage
  logic        [CNT_W-1:0]  count_q [DEPTH];
  logic signed [ACC_W-1:0]  acc_q   [DEPTH][CHANNELS];

  // Output register
  logic                       out_valid_q;
  logic [ADDR_W-1:0]          out_addr_q;
  logic [CHANNELS*DATA_W-1:0] out_data_q;
  logic [CHANNELS*DATA_W-1:0] out_data_d;

  // Read-modify-write datapath for the addressed entry
  logic                       accept;
  logic                       complete;
  logic [CNT_W-1:0]           cur_cnt;
  logic signed [DATA_W-1:0]   smp    [CHANNELS];
  logic signed [ACC_W-1:0]    smp_x  [CHANNELS];
  logic signed [ACC_W-1:0]    acc_d  [CHANNELS];

  assign in_ready  = !clear && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign cur_cnt   = count_q[in_addr];
  assign complete  = accept && (cur_cnt == LAST_CNT);

  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  always_comb begin
    out_data_d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      smp[k]   = in_data[k*DATA_W +: DATA_W];
      smp_x[k] = {{(ACC_W-DATA_W){smp[k][DATA_W-1]}}, smp[k]};
      acc_d[k] = smp_x[k];
      if (cur_cnt != '0) begin
        if (mode) begin
          acc_d[k] = acc_q[in_addr][k] + smp_x[k];
        end else if (acc_q[in_addr][k] > smp_x[k]) begin
          acc_d[k] = acc_q[in_addr][k];
        end
      end
      // Max results always fit DATA_W; the shifted sum of WIN_ELEMS
      // DATA_W-wide samples does too, so truncation loses nothing.
      if (mode) begin
        out_data_d[k*DATA_W +: DATA_W] = DATA_W'(acc_d[k] >>> CNT_W);
      end else begin
        out_data_d[k*DATA_W +: DATA_W] = DATA_W'(acc_d[k]);
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (count_q[i] != '0) begin
        busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        count_q[i] <= '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
          acc_q[i][k] <= '0;
        end
      end
    end else if (clear) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        count_q[i] <= '0;
      end
    end else if (accept) begin
      count_q[in_addr] <= complete ? '0 : cur_cnt + CNT_W'(1);
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        acc_q[in_addr][k] <= acc_d[k];
      end
    end
  end

  // A completion can only happen while the register is empty or being
  // drained this cycle, so loading takes priority and out_valid never bubbles.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= in_addr;
      out_data_q  <= out_data_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

endmodule
